mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (1-cycle read latency) between instruction fetch (IF) and data load/store (D).
//  Grants one access per cycle and builds byte-lane write enables and lane-swapped store data.
//  Tracks the in-flight access and routes the returned word to its owner.
//  Exports the registered offset/size/op of a D load, aligned with mem_rdata, to the load-formatting stage.
// PARAMETERS
//  STARVE_LIMIT  3  consecutive cycles IF may lose arbitration before it wins once (1..15)
//  MEM_AW        14 RAM word-address width; mem_addr = addr[MEM_AW+1:2]
// PORTS
//  clk          in   1   single clock; all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  if_req       in   1   IF request; held until if_gnt
//  if_addr      in   32  IF byte address; word-aligned
//  if_gnt       out  1   IF accepted this cycle (comb)
//  if_valid     out  1   IF read data valid (registered)
//  if_rdata     out  32  raw RAM word for IF
//  d_req        in   1   D request; held until d_gnt
//  d_op         in   2   00 disable, 01 read-sext, 10 read-zext, 11 write
//  d_size       in   2   00 byte, 01 halfword, 10 word
//  d_addr       in   32  D byte address
//  d_wdata      in   32  store value, LSB-justified
//  d_gnt        out  1   D accepted this cycle (comb)
//  d_valid      out  1   D response (load data or store ack), registered
//  d_err        out  1   with d_valid: misaligned access, no RAM side effect
//  d_off_q      out  2   d_addr[1:0] of the responding load
//  d_size_q     out  2   d_size of the responding load
//  d_op_q       out  2   d_op of the responding access
//  mem_en       out  1   RAM enable (comb)
//  mem_we       out  4   byte write enables; bit3 = lane [31:24] = byte offset 0
//  mem_addr     out  MEM_AW  RAM word address
//  mem_wdata    out  32  lane-arranged store data
//  mem_rdata    in   32  RAM output, valid cycle after mem_en
// BEHAVIOUR
//  Reset: if_gnt=d_gnt=0, if_valid=d_valid=d_err=0, d_*_q=0, mem_en=0, mem_we=0, starve_cnt=0, pend=NONE.
//  Effective D request: d_req && d_op!=00. d_req with d_op=00 is ignored (no gnt).
//  Arbitration each cycle: D wins over IF unless starve_cnt==STARVE_LIMIT, then IF wins.
//  starve_cnt: +1 when IF requests and D wins; cleared when if_gnt; saturates at STARVE_LIMIT.
//  Only one gnt per cycle; the loser holds its request; address and data are sampled in the gnt cycle.
//  Issue (gnt cycle T): mem_en=1 and mem_addr from the winner, except a misaligned D access (mem_en=0).
//  Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
//  Response at T+1: pend register {owner, err, op, size, off}.
//    IF: if_valid=1, if_rdata=mem_rdata.
//    D: d_valid=1, d_err=err, d_*_q from pend.
//    D write: ack only. d_rdata is not produced; the formatting stage consumes mem_rdata and d_*_q.
//  Fully pipelined: new grant allowed in T+1; sustained throughput 1 access/cycle; read latency 1.
//  Store lanes, k=addr[1:0]:
//    byte: we bit(3-k), value d_wdata[7:0] in that lane.
//    half: k=0 -> we=1100, {d[7:0],d[15:8]} in [31:16]; k=2 -> we=0011, same pair in [15:0].
//    word: we=1111, mem_wdata={d[7:0],d[15:8],d[23:16],d[31:24]}.
//  Unused lanes of mem_wdata are 0. mem_we=0 for reads and faults.
//  Invalid d_size=11: treated as misaligned (d_err=1).
//  Simultaneous: IF and D in the same cycle follow the priority rule; the response of T-1 and the grant at T coexist.
//  Reset asserted mid-operation clears pend; no valid is emitted for a dropped access.
// STRUCTURE
//  Shared package mem_pkg:
//    MEM_DISABLE/READ_SEXT/READ_ZEXT/WRITE
//    BYTE/HALFWORD/WORD
//    owner enum {NONE, IF, D}
//  One sub-module, store_lane_gen: comb, (size, off, wdata) -> (we, wdata_lanes, misaligned).
//  Arbiter, starvation counter and pend register stay in the top.
// TESTING
//  1. IF only, addr 0x10: if_gnt same cycle, mem_addr=4, if_valid next cycle with if_rdata=mem_rdata.
//  2. sb 0xAB @0x3: mem_we=0001, mem_wdata=0x000000AB. sh 0x1234 @0x2: we=0011, wdata=0x00003412.
//  3. sw 0x11223344 @0x8: we=1111, wdata=0x44332211, d_valid next cycle, d_err=0.
//  4. lw @0x6: d_gnt=1, mem_en=0, next cycle d_valid=1, d_err=1, no write.
//  5. IF+D both held for 5 cycles, STARVE_LIMIT=3: grants D,D,D,IF,D; back-to-back valids each cycle.
//  6. rst_n low the cycle after a D load grant: d_valid stays 0, all outputs at reset values, clean restart.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the memory port arbiter
// Purpose: operation/size codes of the D port, the response owner and the
//          in-flight (pend) record carried from grant to response.
// Ports:   none (package)
package mem_pkg;

  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;

  localparam logic [1:0] MEM_BYTE      = 2'b00;
  localparam logic [1:0] MEM_HALFWORD  = 2'b01;
  localparam logic [1:0] MEM_WORD      = 2'b10;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_D    = 2'd2
  } ownerT;

  typedef struct packed {
    ownerT      owner;
    logic       err;
    logic [1:0] op;
    logic [1:0] size;
    logic [1:0] off;
  } pendT;

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - byte-lane write enables and lane-arranged store data
// Purpose: maps an LSB-justified store value onto RAM lanes, where byte
//          offset 0 lives in lane [31:24], and flags misaligned accesses.
// Ports:   size/off/wdata in; we (bit3 = offset 0), wdataLanes, misaligned out.
module store_lane_gen
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  we,
  output logic [31:0] wdataLanes,
  output logic        misaligned
);

  // Lane shift for a byte at offset k is 8*(3-k); for two bits 3-k == ~k.
  logic [4:0] byteShift;
  assign byteShift = {~off, 3'b000};

  always_comb begin
    we         = 4'b0000;
    wdataLanes = 32'h0;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        we         = 4'b1000 >> off;
        wdataLanes = {24'h0, wdata[7:0]} << byteShift;
      end
      MEM_HALFWORD: begin
        if (off[0]) begin
          misaligned = 1'b1;
        end else if (off[1]) begin
          we         = 4'b0011;
          wdataLanes = {16'h0, wdata[7:0], wdata[15:8]};
        end else begin
          we         = 4'b1100;
          wdataLanes = {wdata[7:0], wdata[15:8], 16'h0};
        end
      end
      MEM_WORD: begin
        if (off != 2'b00) begin
          misaligned = 1'b1;
        end else begin
          we         = 4'b1111;
          wdataLanes = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
        end
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF / D arbiter in front of a 1-cycle single-port RAM
// Purpose: grants one access per cycle (D first, IF after STARVE_LIMIT losses),
//          drives the RAM, and returns the response one cycle later to its owner.
// Ports:   if_req/if_addr -> if_gnt, if_valid/if_rdata
//          d_req/d_op/d_size/d_addr/d_wdata -> d_gnt, d_valid/d_err/d_*_q
//          mem_en/mem_we/mem_addr/mem_wdata -> RAM, mem_rdata <- RAM
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int MEM_AW       = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [1:0]        d_op,
  input  logic [1:0]        d_size,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic              d_err,
  output logic [1:0]        d_off_q,
  output logic [1:0]        d_size_q,
  output logic [1:0]        d_op_q,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic        dEff;
  logic        ifWin;
  logic        dWin;
  logic [3:0]  starveCnt;
  logic [3:0]  laneWe;
  logic [31:0] laneData;
  logic        laneMis;
  pendT        pend;
  pendT        pendNext;
  logic        unusedAddrBits;

  store_lane_gen uLanes (
    .size       (d_size),
    .off        (d_addr[1:0]),
    .wdata      (d_wdata),
    .we         (laneWe),
    .wdataLanes (laneData),
    .misaligned (laneMis)
  );

  // Grants are held off while reset is asserted so nothing is accepted
  // that the cleared pend register would then drop.
  assign dEff   = d_req && (d_op != MEM_DISABLE);
  assign ifWin  = rst_n && if_req && (!dEff || (starveCnt == 4'(STARVE_LIMIT)));
  assign dWin   = rst_n && dEff && !ifWin;
  assign if_gnt = ifWin;
  assign d_gnt  = dWin;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_wdata = 32'h0;
    mem_addr  = if_addr[MEM_AW+1:2];
    pendNext  = '0;
    if (ifWin) begin
      mem_en         = 1'b1;
      pendNext.owner = OWNER_IF;
    end else if (dWin) begin
      mem_addr       = d_addr[MEM_AW+1:2];
      // A misaligned access is answered with d_err and never touches the RAM.
      mem_en         = !laneMis;
      pendNext.owner = OWNER_D;
      pendNext.err   = laneMis;
      pendNext.op    = d_op;
      pendNext.size  = d_size;
      pendNext.off   = d_addr[1:0];
      if ((d_op == MEM_WRITE) && !laneMis) begin
        mem_we    = laneWe;
        mem_wdata = laneData;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= 4'd0;
      pend      <= '0;
    end else begin
      pend <= pendNext;
      if (ifWin) begin
        starveCnt <= 4'd0;
      end else if (if_req && dWin && (starveCnt != 4'(STARVE_LIMIT))) begin
        starveCnt <= starveCnt + 4'd1;
      end
    end
  end

  assign if_valid = (pend.owner == OWNER_IF);
  assign if_rdata = mem_rdata;
  assign d_valid  = (pend.owner == OWNER_D);
  assign d_err    = pend.err;
  assign d_off_q  = pend.off;
  assign d_size_q = pend.size;
  assign d_op_q   = pend.op;

  assign unusedAddrBits = ^{if_addr[1:0], if_addr[31:MEM_AW+2], d_addr[31:MEM_AW+2]};

endmodule
